match_controller: RTL and testbench

Top-level game sequencer for the head-soccer datapath.
- Owns match state, scores and the countdown clock.
- Gates sprite and ball motion through `play_en`.
- Issues single-cycle position-reset pulses to the character and ball blocks.
- Replaces the ad-hoc goal-reset wiring. Consumes goal strobes from the goal detector and drives the score overlay and timer overlay inputs of the renderer.

---
 rtl/match_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_match_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Head-soccer match sequencer: match state, scores, countdown clock and kickoff/goal pacing.
// Optional pause support is built when MATCH_CTRL_PAUSE_EN is defined.
module match_controller #(
  parameter int WIN_SCORE      = 5,
  parameter int MATCH_SECONDS  = 90,
  parameter int FPS            = 60,
  parameter int KICKOFF_FRAMES = 60,
  parameter int FREEZE_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic [2:0] state,
  output logic       play_en,
  output logic       pos_reset,
  output logic       goal_flash,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [6:0] time_sec,
  output logic [1:0] winner
);

  localparam int FRAME_MAX = (KICKOFF_FRAMES > FREEZE_FRAMES) ? KICKOFF_FRAMES : FREEZE_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int SEC_W     = (FPS > 1) ? $clog2(FPS) : 1;

  localparam logic [FRAME_W-1:0] KICK_LAST   = FRAME_W'(KICKOFF_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FREEZE_LAST = FRAME_W'(FREEZE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE   = FRAME_W'(1);
  localparam logic [SEC_W-1:0]   SEC_LAST    = SEC_W'(FPS - 1);
  localparam logic [SEC_W-1:0]   SEC_ONE     = SEC_W'(1);
  localparam logic [3:0]         WIN         = 4'(WIN_SCORE);
  localparam logic [6:0]         SECS        = 7'(MATCH_SECONDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICKOFF = 3'd1,
    S_PLAY    = 3'd2,
    S_GOAL    = 3'd3,
    S_OVER    = 3'd4,
    S_PAUSE   = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_play_en;
  logic               r_pos_reset;
  logic               r_goal_flash;
  logic [3:0]         r_score_p1;
  logic [3:0]         r_score_p2;
  logic [6:0]         r_time_sec;
  logic [1:0]         r_winner;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [SEC_W-1:0]   r_sec_cnt;
  logic               r_start_q;
  logic               r_start_armed;

  logic               w_start_rise;
  logic               w_credit_p1;
  logic               w_credit_p2;
  logic [3:0]         w_score_p1_nxt;
  logic [3:0]         w_score_p2_nxt;
  logic               w_win_goal;
  logic               w_sec_wrap;
  logic               w_expire;
  logic [1:0]         w_winner_goal;
  logic [1:0]         w_winner_cmp;

  // The edge register clears to 0 on reset, so an arm flag (set once the button is
  // seen released) keeps a button held through reset from looking like a fresh press.
  assign w_start_rise = start_btn & ~r_start_q & r_start_armed;

  assign w_credit_p1    = goal_p1 & ~goal_p2 & (r_score_p1 != WIN);
  assign w_credit_p2    = goal_p2 & ~goal_p1 & (r_score_p2 != WIN);
  assign w_score_p1_nxt = r_score_p1 + {3'b000, w_credit_p1};
  assign w_score_p2_nxt = r_score_p2 + {3'b000, w_credit_p2};
  assign w_win_goal     = (w_credit_p1 & (w_score_p1_nxt == WIN)) |
                          (w_credit_p2 & (w_score_p2_nxt == WIN));
  assign w_winner_goal  = w_credit_p1 ? 2'd1 : 2'd2;
  assign w_winner_cmp   = (w_score_p1_nxt > w_score_p2_nxt) ? 2'd1 :
                          (w_score_p2_nxt > w_score_p1_nxt) ? 2'd2 : 2'd3;

  assign w_sec_wrap = frame_tick & (r_sec_cnt == SEC_LAST);
  assign w_expire   = w_sec_wrap & (r_time_sec == 7'd1);

`ifdef MATCH_CTRL_PAUSE_EN
  logic r_pause_q;
  logic r_pause_armed;
  logic w_pause_rise;
  assign w_pause_rise = pause_btn & ~r_pause_q & r_pause_armed;
`else
  logic w_unused_pause;
  assign w_unused_pause = pause_btn;
`endif

  // NOTE: every register here is sequential state, so all assignments in this block are
  // non-blocking; later assignments in the same cycle override the defaults at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_play_en     <= 1'b0;
      r_pos_reset   <= 1'b0;
      r_goal_flash  <= 1'b0;
      r_score_p1    <= 4'd0;
      r_score_p2    <= 4'd0;
      r_time_sec    <= SECS;
      r_winner      <= 2'd0;
      r_frame_cnt   <= '0;
      r_sec_cnt     <= '0;
      r_start_q     <= 1'b0;
      r_start_armed <= 1'b0;
`ifdef MATCH_CTRL_PAUSE_EN
      r_pause_q     <= 1'b0;
      r_pause_armed <= 1'b0;
`endif
    end else begin
      r_start_q     <= start_btn;
      r_start_armed <= r_start_armed | ~start_btn;
`ifdef MATCH_CTRL_PAUSE_EN
      r_pause_q     <= pause_btn;
      r_pause_armed <= r_pause_armed | ~pause_btn;
`endif
      r_pos_reset   <= 1'b0;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_rise) begin
            r_score_p1   <= 4'd0;
            r_score_p2   <= 4'd0;
            r_time_sec   <= SECS;
            r_frame_cnt  <= '0;
            r_sec_cnt    <= '0;
            r_winner     <= 2'd0;
            r_pos_reset  <= 1'b1;
            r_play_en    <= 1'b0;
            r_goal_flash <= 1'b0;
            r_state      <= S_KICKOFF;
          end
        end

        S_KICKOFF: begin
          if (frame_tick) begin
            if (r_frame_cnt == KICK_LAST) begin
              r_frame_cnt <= '0;
              r_play_en   <= 1'b1;
              r_state     <= S_PLAY;
            end else begin
              r_frame_cnt <= r_frame_cnt + FRAME_ONE;
            end
          end
        end

        S_PLAY: begin
`ifdef MATCH_CTRL_PAUSE_EN
          if (w_pause_rise) begin
            r_play_en <= 1'b0;
            r_state   <= S_PAUSE;
          end else
`endif
          begin
            if (frame_tick) begin
              r_sec_cnt <= w_sec_wrap ? '0 : r_sec_cnt + SEC_ONE;
              if (w_sec_wrap) r_time_sec <= r_time_sec - 7'd1;
            end

            // Expiry outranks every goal outcome; a goal on the same cycle is still credited.
            if (w_expire) begin
              r_score_p1 <= w_score_p1_nxt;
              r_score_p2 <= w_score_p2_nxt;
              r_winner   <= w_winner_cmp;
              r_play_en  <= 1'b0;
              r_state    <= S_OVER;
            end else if (goal_p1 && goal_p2) begin
              r_frame_cnt <= '0;
              r_pos_reset <= 1'b1;
              r_play_en   <= 1'b0;
              r_state     <= S_KICKOFF;
            end else if (goal_p1 || goal_p2) begin
              r_score_p1 <= w_score_p1_nxt;
              r_score_p2 <= w_score_p2_nxt;
              r_play_en  <= 1'b0;
              if (w_win_goal) begin
                r_winner <= w_winner_goal;
                r_state  <= S_OVER;
              end else begin
                r_frame_cnt  <= '0;
                r_goal_flash <= 1'b1;
                r_state      <= S_GOAL;
              end
            end
          end
        end

        S_GOAL: begin
          if (frame_tick) begin
            if (r_frame_cnt == FREEZE_LAST) begin
              r_frame_cnt  <= '0;
              r_pos_reset  <= 1'b1;
              r_goal_flash <= 1'b0;
              r_state      <= S_KICKOFF;
            end else begin
              r_frame_cnt <= r_frame_cnt + FRAME_ONE;
            end
          end
        end

`ifdef MATCH_CTRL_PAUSE_EN
        S_PAUSE: begin
          if (w_pause_rise) begin
            r_play_en <= 1'b1;
            r_state   <= S_PLAY;
          end
        end
`endif

        default: begin
          r_play_en    <= 1'b0;
          r_goal_flash <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign play_en    = r_play_en;
  assign pos_reset  = r_pos_reset;
  assign goal_flash = r_goal_flash;
  assign score_p1   = r_score_p1;
  assign score_p2   = r_score_p2;
  assign time_sec   = r_time_sec;
  assign winner     = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with WIN_SCORE=3, MATCH_SECONDS=5, FPS=4,
// KICKOFF_FRAMES=2, FREEZE_FRAMES=3; expected values are worked out by hand per step.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start_btn;
  logic       pause_btn;
  logic       goal_p1;
  logic       goal_p2;
  logic [2:0] state;
  logic       play_en;
  logic       pos_reset;
  logic       goal_flash;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [6:0] time_sec;
  logic [1:0] winner;

  int n_tests = 0;
  int n_fail  = 0;

  match_controller #(
    .WIN_SCORE      (3),
    .MATCH_SECONDS  (5),
    .FPS            (4),
    .KICKOFF_FRAMES (2),
    .FREEZE_FRAMES  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .goal_p1    (goal_p1),
    .goal_p2    (goal_p2),
    .state      (state),
    .play_en    (play_en),
    .pos_reset  (pos_reset),
    .goal_flash (goal_flash),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .time_sec   (time_sec),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are read 1 time unit after the edge.
  task automatic cyc(input logic ft, input logic g1, input logic g2);
    frame_tick = ft;
    goal_p1    = g1;
    goal_p2    = g2;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    goal_p1    = 1'b0;
    goal_p2    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_state", state, 0);
    check("rst_time", time_sec, 5);
    check("rst_play_en", play_en, 0);
    check("rst_pos_reset", pos_reset, 0);
    check("rst_winner", winner, 0);
    check("rst_scores", {score_p1, score_p2}, 0);
    cyc(0, 0, 0);

    // Start a match
    start_btn = 1'b1;
    cyc(0, 0, 0);
    check("start_state", state, 1);
    check("start_pos_reset", pos_reset, 1);
    cyc(0, 0, 0);
    check("start_pos_reset_1cyc", pos_reset, 0);
    start_btn = 1'b0;
    ticks(1);
    check("kick_tick1_state", state, 1);
    check("kick_tick1_play_en", play_en, 0);
    ticks(1);
    check("kick_tick2_state", state, 2);
    check("kick_tick2_play_en", play_en, 1);
    start_btn = 1'b1;
    cyc(0, 0, 0);
    check("start_in_play_state", state, 2);
    check("start_in_play_pos_reset", pos_reset, 0);
    start_btn = 1'b0;
    cyc(0, 0, 0);

    // Countdown and draw
    ticks(3);
    check("cd_3ticks_time", time_sec, 5);
    ticks(1);
    check("cd_4ticks_time", time_sec, 4);
    ticks(15);
    check("cd_19ticks_time", time_sec, 1);
    check("cd_19ticks_state", state, 2);
    ticks(1);
    check("cd_20ticks_time", time_sec, 0);
    check("cd_over_state", state, 4);
    check("cd_draw_winner", winner, 3);
    check("cd_over_play_en", play_en, 0);
    cyc(0, 1, 0);
    check("over_goal_ignored", score_p1, 0);

    // Rematch from OVER, then a goal cycle
    start_btn = 1'b1;
    cyc(0, 0, 0);
    check("rematch1_state", state, 1);
    check("rematch1_time", time_sec, 5);
    check("rematch1_winner", winner, 0);
    start_btn = 1'b0;
    ticks(2);
    check("rematch1_play", state, 2);
    cyc(0, 0, 1);
    check("goal_p2_score", score_p2, 1);
    check("goal_state", state, 3);
    check("goal_flash_on", goal_flash, 1);
    check("goal_play_en", play_en, 0);
    cyc(0, 1, 0);
    check("goal_in_goal_ignored", score_p1, 0);
    ticks(2);
    check("goal_2ticks_state", state, 3);
    check("goal_time_frozen", time_sec, 5);
    ticks(1);
    check("goal_3ticks_state", state, 1);
    check("goal_pos_reset", pos_reset, 1);
    check("goal_flash_off", goal_flash, 0);
    cyc(0, 0, 0);
    check("goal_pos_reset_1cyc", pos_reset, 0);
    ticks(2);
    check("goal_back_play", state, 2);

    // Win by P1
    cyc(0, 1, 0);
    check("win_g1_score", score_p1, 1);
    check("win_g1_state", state, 3);
    ticks(5);
    check("win_g1_replay", state, 2);
    cyc(0, 1, 0);
    check("win_g2_score", score_p1, 2);
    ticks(5);
    check("win_g2_replay", state, 2);
    cyc(0, 1, 0);
    check("win_g3_score", score_p1, 3);
    check("win_state", state, 4);
    check("win_winner", winner, 1);
    check("win_play_en", play_en, 0);
    check("win_score_p2_held", score_p2, 1);

    start_btn = 1'b1;
    cyc(0, 0, 0);
    check("rematch2_scores", {score_p1, score_p2}, 0);
    check("rematch2_time", time_sec, 5);
    check("rematch2_winner", winner, 0);
    check("rematch2_state", state, 1);
    start_btn = 1'b0;
    ticks(2);
    check("rematch2_play", state, 2);

    // Simultaneous goals void the play
    cyc(0, 1, 1);
    check("void_scores", {score_p1, score_p2}, 0);
    check("void_state", state, 1);
    check("void_pos_reset", pos_reset, 1);
    ticks(2);
    check("void_back_play", state, 2);

    // Goal on the expiry cycle
    ticks(19);
    check("exp_pre_time", time_sec, 1);
    check("exp_pre_state", state, 2);
    cyc(1, 0, 1);
    check("exp_score_p2", score_p2, 1);
    check("exp_time", time_sec, 0);
    check("exp_state", state, 4);
    check("exp_winner", winner, 2);

    // Reset mid-KICKOFF with start held
    start_btn = 1'b1;
    cyc(0, 0, 0);
    check("pre_rst_state", state, 1);
    ticks(1);
    reset = 1'b1;
    cyc(1, 1, 0);
    check("rst2_state", state, 0);
    check("rst2_scores", {score_p1, score_p2}, 0);
    check("rst2_time", time_sec, 5);
    check("rst2_winner", winner, 0);
    check("rst2_flags", {play_en, pos_reset, goal_flash}, 0);
    reset = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("held_start_no_fire", state, 0);
    check("held_start_no_pulse", pos_reset, 0);
    start_btn = 1'b0;
    cyc(0, 0, 0);
    start_btn = 1'b1;
    cyc(0, 0, 0);
    check("fresh_start_state", state, 1);
    check("fresh_start_pulse", pos_reset, 1);
    start_btn = 1'b0;
    cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
